// File: rtl/vga_token_plotter_if.sv
// Handshake and pixel bus between the game FSM / VGA adapter side (master) and the plotter (slave).
interface vga_token_plotter_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               go;
    logic               mode;
    logic               erase;
    logic               player;
    logic [2:0]         col;
    logic [2:0]         row;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] colour;
    logic               plot;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output go, mode, erase, player, col, row,
        input  x, y, colour, plot, busy, done, err
    );

    modport slave (
        input  go, mode, erase, player, col, row,
        output x, y, colour, plot, busy, done, err
    );
endinterface

// File: rtl/vga_token_plotter.sv
// Scans one TILE_W x TILE_H block per go edge (player token or column pointer), one plot per cycle.
// Optional macro ROUNDED_TOKEN_EN suppresses the four corner plots of player tokens.
module vga_token_plotter #(
    parameter int                 TILE_W   = 8,
    parameter int                 TILE_H   = 8,
    parameter int                 NUM_COLS = 7,
    parameter int                 NUM_ROWS = 6,
    parameter int                 ORIGIN_X = 16,
    parameter int                 ORIGIN_Y = 16,
    parameter int                 PTR_Y    = 4,
    parameter int                 X_W      = 8,
    parameter int                 Y_W      = 7,
    parameter int                 COLOR_W  = 3,
    parameter logic [COLOR_W-1:0] P0_COLOR = 3'b100,
    parameter logic [COLOR_W-1:0] P1_COLOR = 3'b110,
    parameter logic [COLOR_W-1:0] BG_COLOR = 3'b000
) (
    input  logic                 clk,
    input  logic                 resetn,
    vga_token_plotter_if.slave   bus
);
    localparam int PX_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int PY_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(TILE_W - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(TILE_H - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t             state, state_next;
    logic               go_q;
    logic               mode_q, mode_next;
    logic [X_W-1:0]     base_x, base_x_next;
    logic [Y_W-1:0]     base_y, base_y_next;
    logic [PX_W-1:0]    px, px_next;
    logic [PY_W-1:0]    py, py_next;
    logic [X_W-1:0]     x_next;
    logic [Y_W-1:0]     y_next;
    logic [COLOR_W-1:0] colour_next;
    logic               plot_next, busy_next, done_next, err_next;
    logic               emit;
    logic               request, request_valid, last_pixel;

    assign request       = bus.go & ~go_q;
    assign request_valid = (int'(bus.col) < NUM_COLS) && (!bus.mode || (int'(bus.row) < NUM_ROWS));
    assign last_pixel    = (px == PX_LAST) && (py == PY_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            go_q  <= 1'b0;
        end else begin
            state <= state_next;
            go_q  <= bus.go;
        end
    end

    // emit marks cycles whose registered x/y describe a scanned pixel; the pixel address is
    // always derived from the latched base plus the next scan position.
    always_comb begin
        state_next  = state;
        mode_next   = mode_q;
        base_x_next = base_x;
        base_y_next = base_y;
        px_next     = px;
        py_next     = py;
        x_next      = bus.x;
        y_next      = bus.y;
        colour_next = bus.colour;
        emit        = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        err_next    = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (request_valid) begin
                        state_next  = DRAW;
                        mode_next   = bus.mode;
                        base_x_next = X_W'(ORIGIN_X + TILE_W * int'(bus.col));
                        base_y_next = bus.mode ? Y_W'(ORIGIN_Y + TILE_H * int'(bus.row)) : Y_W'(PTR_Y);
                        colour_next = bus.erase ? BG_COLOR : (bus.player ? P1_COLOR : P0_COLOR);
                        px_next     = '0;
                        py_next     = '0;
                        emit        = 1'b1;
                        busy_next   = 1'b1;
                    end else begin
                        err_next    = 1'b1;
                    end
                end
            end
            DRAW: begin
                busy_next = 1'b1;
                if (last_pixel) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    if (px == PX_LAST) begin
                        px_next = '0;
                        py_next = py + 1'b1;
                    end else begin
                        px_next = px + 1'b1;
                    end
                    emit = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (emit) begin
            x_next = base_x_next + X_W'(px_next);
            y_next = base_y_next + Y_W'(py_next);
        end
        plot_next = emit;
`ifdef ROUNDED_TOKEN_EN
        if (mode_next && (px_next == '0 || px_next == PX_LAST) && (py_next == '0 || py_next == PY_LAST))
            plot_next = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q     <= 1'b0;
            base_x     <= '0;
            base_y     <= '0;
            px         <= '0;
            py         <= '0;
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= '0;
            bus.plot   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            mode_q     <= mode_next;
            base_x     <= base_x_next;
            base_y     <= base_y_next;
            px         <= px_next;
            py         <= py_next;
            bus.x      <= x_next;
            bus.y      <= y_next;
            bus.colour <= colour_next;
            bus.plot   <= plot_next;
            bus.busy   <= busy_next;
            bus.done   <= done_next;
            bus.err    <= err_next;
        end
    end
endmodule
